divider_iter_8b: RTL

Multi-cycle unsigned 8-bit divider built around the team's gate-level 8-bit subtractor (`Subtractor_8b_GL`). It sequences one trial subtraction per cycle with a restoring shift/subtract algorithm. It produces quotient and remainder behind latency-insensitive val/rdy handshakes. It sits beside the ALU, so one subtractor instance serves the whole divide instead of eight unrolled copies.

---
 rtl/divider_iter_8b.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/divider_iter_8b.sv
// ---------------------------------------------------------------------------
// divider_iter_8b -- multi-cycle unsigned 8-bit restoring divider
//
// One trial subtraction per cycle through a single gate-level 8-bit
// subtractor (Subtractor_8b_GL, defined below). Requests and results move
// over val/rdy handshakes.
//
// Optional feature macro: DIVIDER_ITER_8B_DIV0_FAST_EN
//   defined   : a zero divisor skips CALC. The result is valid the cycle after
//               the request, with ostream_div0=1.
//   undefined : a zero divisor runs all eight steps. ostream_div0 is tied 0.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous, active-low reset
//   istream_val/rdy   request handshake
//   istream_dividend  unsigned dividend
//   istream_divisor   unsigned divisor
//   ostream_val/rdy   result handshake
//   ostream_quotient  unsigned quotient (0xFF for a zero divisor)
//   ostream_remainder unsigned remainder (dividend for a zero divisor)
//   ostream_div0      divisor was zero (fast-path build only)
// ---------------------------------------------------------------------------

// Ripple-borrow subtractor: diff = a - b mod 256.
// borrow_out=1 exactly when a < b.
module Subtractor_8b_GL (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       borrow_out
);
  logic [8:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
    assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
  end

  assign borrow_out = borrow[8];
endmodule

module divider_iter_8b (
  input  logic       clk,
  input  logic       rst,
  input  logic       istream_val,
  output logic       istream_rdy,
  input  logic [7:0] istream_dividend,
  input  logic [7:0] istream_divisor,
  output logic       ostream_val,
  input  logic       ostream_rdy,
  output logic [7:0] ostream_quotient,
  output logic [7:0] ostream_remainder,
  output logic       ostream_div0
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] quo_q, quo_d;
  logic [7:0] dvs_q, dvs_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rdy_q, rdy_d;
  logic       val_q, val_d;
  logic [7:0] quo_out_q, quo_out_d;
  logic [7:0] rem_out_q, rem_out_d;
`ifdef DIVIDER_ITER_8B_DIV0_FAST_EN
  logic       div0_q, div0_d;
`endif

  logic [8:0] sh;
  logic [7:0] diff;
  logic       borrow;
  logic       fits;
  logic       in_fire;
  logic       out_fire;

  // The partial remainder is widened by the next dividend bit. If its top
  // bit is set, the shifted value is at least 256 and always exceeds dvs.
  // That holds even though the subtractor only sees the low 8 bits.
  assign sh   = {rem_q, quo_q[7]};
  assign fits = sh[8] | ~borrow;

  Subtractor_8b_GL u_sub (
    .a          (sh[7:0]),
    .b          (dvs_q),
    .diff       (diff),
    .borrow_out (borrow)
  );

  // Ready is registered, but it is masked while reset is held. No request
  // can slip in during the reset cycle.
  assign istream_rdy       = rdy_q & rst;
  assign ostream_val       = val_q;
  assign ostream_quotient  = quo_out_q;
  assign ostream_remainder = rem_out_q;
`ifdef DIVIDER_ITER_8B_DIV0_FAST_EN
  assign ostream_div0      = div0_q;
`else
  assign ostream_div0      = 1'b0;
`endif

  assign in_fire  = istream_val & istream_rdy;
  assign out_fire = val_q & ostream_rdy;

  // Next-state logic. The result registers load on the transition into
  // DONE. They then stay untouched until the next result, so the outputs
  // stay put under backpressure.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    rdy_d     = rdy_q;
    val_d     = val_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
`ifdef DIVIDER_ITER_8B_DIV0_FAST_EN
    div0_d    = div0_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          rem_d = 8'h00;
          quo_d = istream_dividend;
          dvs_d = istream_divisor;
          cnt_d = 4'd0;
          rdy_d = 1'b0;
`ifdef DIVIDER_ITER_8B_DIV0_FAST_EN
          if (istream_divisor == 8'h00) begin
            state_d   = DONE;
            val_d     = 1'b1;
            quo_out_d = 8'hFF;
            rem_out_d = istream_dividend;
            div0_d    = 1'b1;
          end else begin
            state_d   = CALC;
            div0_d    = 1'b0;
          end
`else
          state_d = CALC;
`endif
        end
      end

      CALC: begin
        rem_d = fits ? diff : sh[7:0];
        quo_d = {quo_q[6:0], fits};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          state_d   = DONE;
          val_d     = 1'b1;
          quo_out_d = quo_d;
          rem_out_d = rem_d;
        end
      end

      DONE: begin
        // Ready rises only in the following cycle. A request offered in
        // the same cycle as the result handshake is therefore refused.
        if (out_fire) begin
          state_d = IDLE;
          val_d   = 1'b0;
          rdy_d   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        val_d   = 1'b0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // All state in one place. Reset drops any operation in flight and clears
  // the visible result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rem_q     <= 8'h00;
      quo_q     <= 8'h00;
      dvs_q     <= 8'h00;
      cnt_q     <= 4'd0;
      rdy_q     <= 1'b1;
      val_q     <= 1'b0;
      quo_out_q <= 8'h00;
      rem_out_q <= 8'h00;
`ifdef DIVIDER_ITER_8B_DIV0_FAST_EN
      div0_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      val_q     <= val_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
`ifdef DIVIDER_ITER_8B_DIV0_FAST_EN
      div0_q    <= div0_d;
`endif
    end
  end

endmodule
